// File: rtl/fsk_pkg.sv
// Shared state encoding and default framing/tone constants for the FSK transmit path.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } fsk_state_e;

  localparam int         DEF_DATA_W     = 12;
  localparam int         DEF_SYNC_W     = 4;
  localparam logic [3:0] DEF_SYNC_PAT   = 4'b0111;
  localparam int         DEF_BIT_CYCLES = 16;
  localparam int         DEF_HALF_MARK  = 2;
  localparam int         DEF_HALF_SPACE = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsk_tone_gen.sv
// Square-wave tone generator: restarts low on every bit start, half-period chosen by the bit value.
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int HALF_MARK  = DEF_HALF_MARK,
  parameter int HALF_SPACE = DEF_HALF_SPACE
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_start,
  input  logic bit_val,
  output logic fsk_out
);

  localparam int            TW       = $clog2(max2(HALF_MARK, HALF_SPACE)) + 1;
  localparam logic [TW-1:0] MARK_TC  = TW'(HALF_MARK - 1);
  localparam logic [TW-1:0] SPACE_TC = TW'(HALF_SPACE - 1);

  logic [TW-1:0] tone_cnt_reg;
  logic          mark_sel_reg;
  logic [TW-1:0] tone_tc;

  assign tone_tc = mark_sel_reg ? MARK_TC : SPACE_TC;

  // bit_start is a request for the coming cycle, so the restart is already visible on its first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tone_cnt_reg <= '0;
      mark_sel_reg <= 1'b0;
      fsk_out      <= 1'b0;
    end else if (bit_start) begin
      tone_cnt_reg <= '0;
      mark_sel_reg <= bit_val;
      fsk_out      <= 1'b0;
    end else if (tone_cnt_reg == tone_tc) begin
      tone_cnt_reg <= '0;
      fsk_out      <= ~fsk_out;
    end else begin
      tone_cnt_reg <= tone_cnt_reg + TW'(1);
    end
  end

endmodule

// File: rtl/fsk_tx_framer.sv
// One-word buffered framer: prefixes each codeword with a sync pattern and sends it MSB-first as FSK.
module fsk_tx_framer
  import fsk_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                SYNC_W     = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_W'(DEF_SYNC_PAT),
  parameter int                BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int                HALF_MARK  = DEF_HALF_MARK,
  parameter int                HALF_SPACE = DEF_HALF_SPACE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              fsk_out,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_done
);

  localparam int            FW      = SYNC_W + DATA_W;
  localparam int            BW      = $clog2(BIT_CYCLES) + 1;
  localparam int            IW      = $clog2(max2(SYNC_W, DATA_W)) + 1;
  localparam logic [BW-1:0] BIT_TC  = BW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] SYNC_TC = IW'(SYNC_W - 1);
  localparam logic [IW-1:0] DATA_TC = IW'(DATA_W - 1);

  fsk_state_e        state_reg, state_next;
  logic [DATA_W-1:0] buf_reg;
  logic              buf_full_reg;
  logic [FW-1:0]     shreg_reg, shreg_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [IW-1:0]     bit_idx_reg, bit_idx_next;
  logic              accept;
  logic              load;
  logic              bit_end;
  logic              bit_start;
  logic              bit_val;

  assign in_ready = ~buf_full_reg;
  assign accept   = in_valid & ~buf_full_reg;
  assign bit_end  = (bit_cnt_reg == BIT_TC);

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_idx_next = bit_idx_reg;
    load         = 1'b0;
    case (state_reg)
      IDLE: load = buf_full_reg;
      SYNC: begin
        if (bit_end) begin
          shreg_next   = shreg_reg << 1;
          bit_cnt_next = '0;
          if (bit_idx_reg == SYNC_TC) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IW'(1);
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_next   = shreg_reg << 1;
          bit_cnt_next = '0;
          if (bit_idx_reg == DATA_TC) begin
            // A word waiting at frame end goes straight out with no idle gap.
            load         = buf_full_reg;
            state_next   = IDLE;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IW'(1);
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      state_next   = SYNC;
      shreg_next   = {SYNC_PAT, buf_reg};
      bit_cnt_next = '0;
      bit_idx_next = '0;
    end
  end

  // Idle requests a restart every cycle, which pins the tone output low.
  assign bit_start = (bit_cnt_next == '0);
  assign bit_val   = (state_next != IDLE) & shreg_next[FW-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      shreg_reg    <= '0;
      bit_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      busy         <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      if (accept) begin
        buf_reg      <= in_data;
        buf_full_reg <= 1'b1;
      end else if (load) begin
        buf_full_reg <= 1'b0;
      end
      busy        <= (state_next != IDLE);
      frame_start <= load;
      frame_done  <= (state_next == DATA) && (bit_idx_next == DATA_TC) && (bit_cnt_next == BIT_TC);
    end
  end

  fsk_tone_gen #(
    .HALF_MARK (HALF_MARK),
    .HALF_SPACE(HALF_SPACE)
  ) u_tone (
    .clk      (clk),
    .reset    (reset),
    .bit_start(bit_start),
    .bit_val  (bit_val),
    .fsk_out  (fsk_out)
  );

endmodule

// File: tb/tb_fsk_tx_framer.sv
// Scoreboard bench for fsk_tx_framer: default instance plus a reduced-parameter instance.
module tb_fsk_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  vld_v, rdy_v, fsk_v, busy_v, fs_v, fd_v;
  logic [11:0] d0;
  logic [7:0]  d1;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  always #5 clk = ~clk;

  fsk_tx_framer dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(vld_v[0]), .in_ready(rdy_v[0]),
    .fsk_out(fsk_v[0]), .busy(busy_v[0]), .frame_start(fs_v[0]), .frame_done(fd_v[0])
  );

  fsk_tx_framer #(
    .DATA_W(8), .SYNC_W(2), .SYNC_PAT(2'b10), .BIT_CYCLES(12), .HALF_MARK(3), .HALF_SPACE(6)
  ) dut1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(vld_v[1]), .in_ready(rdy_v[1]),
    .fsk_out(fsk_v[1]), .busy(busy_v[1]), .frame_start(fs_v[1]), .frame_done(fd_v[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [11:0] data, input int budget);
    bit   ok;
    logic was;
    ok = 1'b0;
    if (u == 0) d0 = data; else d1 = data[7:0];
    vld_v[u] = 1'b1;
    for (int k = 0; k < budget && !ok; k++) begin
      was = rdy_v[u];
      tick();
      if (was === 1'b1) ok = 1'b1;
    end
    vld_v[u] = 1'b0;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_u%0d: word %h not accepted within %0d cycles, required acceptance", u, data, budget);
    end else if (u == 0) begin
      sb0.push_back({16'h0, 4'b0111, data});
    end else begin
      sb1.push_back({22'h0, 2'b10, data[7:0]});
    end
  endtask

  task automatic check_frame(input int u, input string nm, input int budget);
    int          nbits, bc, hm, hs, half, last, k;
    logic [31:0] expf, obs, expv;
    logic        bitv;
    bit          busy_bad, fs_bad, fd_bad;
    busy_bad = 0; fs_bad = 0; fd_bad = 0;
    nbits = (u == 0) ? 16 : 10;
    bc    = (u == 0) ? 16 : 12;
    hm    = (u == 0) ? 2 : 3;
    hs    = (u == 0) ? 4 : 6;
    k = 0;
    while (fs_v[u] !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_assert++;
    if (fs_v[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start: frame_start=%b after %0d cycles, required 1", nm, fs_v[u], k);
      return;
    end
    n_assert++;
    if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
      n_fail++;
      $display("FAIL %s_sb: frame started with empty scoreboard, required a queued word", nm);
      return;
    end
    expf = (u == 0) ? sb0.pop_front() : sb1.pop_front();
    last = nbits * bc - 1;
    obs  = '0;
    expv = '0;
    for (int i = 0; i <= last; i++) begin
      int b;
      int c;
      b    = i / bc;
      c    = i % bc;
      bitv = expf[nbits-1-b];
      half = bitv ? hm : hs;
      if (c == 0) begin
        obs  = '0;
        expv = '0;
      end
      obs[c]  = fsk_v[u];
      expv[c] = ((c / half) % 2) == 1;
      if (busy_v[u] !== 1'b1) busy_bad = 1;
      if (fs_v[u] !== (i == 0)) fs_bad = 1;
      if (fd_v[u] !== (i == last)) fd_bad = 1;
      if (c == bc - 1) begin
        n_assert++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL %s_bit%0d: tone samples=%h required %h (bit value %b)", nm, b, obs, expv, bitv);
        end
      end
      if (i != last) tick();
    end
    n_assert++;
    if (busy_bad) begin n_fail++; $display("FAIL %s_busy: busy dropped inside frame, required 1 for %0d cycles", nm, last + 1); end
    n_assert++;
    if (fs_bad) begin n_fail++; $display("FAIL %s_fstart: frame_start wrong inside frame, required only on cycle 0", nm); end
    n_assert++;
    if (fd_bad) begin n_fail++; $display("FAIL %s_fdone: frame_done wrong, required only on cycle %0d", nm, last); end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      n_assert++;
      if ({fsk_v[u], busy_v[u], fs_v[u], fd_v[u], rdy_v[u]} !== 5'b00001) begin
        n_fail++;
        $display("FAIL reset_u%0d: fsk,busy,fs,fd,rdy=%b required 00001", u,
                 {fsk_v[u], busy_v[u], fs_v[u], fd_v[u], rdy_v[u]});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit bad;
    bad = 0;
    send(0, 12'h123, 10);
    tick();
    n_assert++;
    if (fs_v[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_start: frame_start=%b required 1", fs_v[0]); end
    repeat (99) tick();
    send(0, 12'h456, 10);
    #2 reset = 1'b0;
    #1;
    n_assert++;
    if ({fsk_v[0], busy_v[0], fs_v[0], fd_v[0], rdy_v[0]} !== 5'b00001) begin
      n_fail++;
      $display("FAIL rmid_async: fsk,busy,fs,fd,rdy=%b required 00001",
               {fsk_v[0], busy_v[0], fs_v[0], fd_v[0], rdy_v[0]});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fs_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || fsk_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) bad = 1;
    end
    n_assert++;
    if (bad) begin n_fail++; $display("FAIL rmid_residual: activity after reset release, required none"); end
    sb0.delete();
  endtask

  task automatic test_single();
    send(0, 12'hA5C, 10);
    n_assert++;
    if (fs_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_buf: fs=%b rdy=%b one cycle after accept, required fs=0 rdy=0", fs_v[0], rdy_v[0]);
    end
    check_frame(0, "single", 1);
    tick();
    n_assert++;
    if (busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_end: busy=%b rdy=%b after frame, required busy=0 rdy=1", busy_v[0], rdy_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    send(0, 12'hFFF, 10);
    fork
      begin
        check_frame(0, "b2b1", 1);
        n_assert++;
        if (rdy_v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_full: in_ready=%b at frame_done, required 0", rdy_v[0]); end
        tick();
        check_frame(0, "b2b2", 0);
      end
      begin
        tick();
        send(0, 12'h000, 10);
      end
    join
    tick();
    n_assert++;
    if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_end: busy=%b after second frame, required 0", busy_v[0]); end
  endtask

  task automatic test_backpressure();
    send(0, 12'h3C9, 10);
    fork
      begin
        check_frame(0, "bp1", 1);
        n_assert++;
        if (rdy_v[0] !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full: in_ready=%b at frame_done, required 0", rdy_v[0]); end
        tick();
        n_assert++;
        if (rdy_v[0] !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_rise: in_ready=%b cycle after load, required 1", rdy_v[0]); end
        check_frame(0, "bp2", 0);
        tick();
        check_frame(0, "bp3", 0);
      end
      begin
        tick();
        send(0, 12'h5A0, 10);
        send(0, 12'h0F1, 600);
      end
    join
    tick();
  endtask

  task automatic test_sweep();
    send(1, 12'h081, 10);
    check_frame(1, "sweep", 1);
    tick();
    n_assert++;
    if (busy_v[1] !== 1'b0) begin n_fail++; $display("FAIL sweep_end: busy=%b after 120-cycle frame, required 0", busy_v[1]); end
  endtask

  task automatic test_idle();
    bit bad0, bad1;
    bad0 = 0; bad1 = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if ({fsk_v[0], busy_v[0], fs_v[0], fd_v[0]} !== 4'b0) bad0 = 1;
      if ({fsk_v[1], busy_v[1], fs_v[1], fd_v[1]} !== 4'b0) bad1 = 1;
    end
    n_assert++;
    if (bad0) begin n_fail++; $display("FAIL idle_u0: activity while idle, required all low"); end
    n_assert++;
    if (bad1) begin n_fail++; $display("FAIL idle_u1: activity while idle, required all low"); end
  endtask

  initial begin
    reset = 1'b0;
    vld_v = 2'b00;
    d0    = '0;
    d1    = '0;
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_reset_mid_frame();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_sweep();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
